seg7_scan_decoder: RTL
======================

Name: seg7_scan_decoder

Overview:
Reverse path of the 7-segment encoder. Samples a multiplexed, active-low common-anode display bus (segments a..g, dp, per-digit anode enables) and recovers the hex value shown on each digit. It requires each scan slot to hold steady before capturing it. Once every digit has been refreshed, it emits a full NDIG-digit frame. Used for display loop-back checking and for snooping an external display.

Parameters:
NDIG, 4, number of multiplexed digits; anode bit i selects digit i; digit 0 is the least significant nibble.
STABLE_CYC, 4, consecutive identical valid samples required before a digit capture; legal range is 1 or more.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
seg_in  input  7  segment bus, active-low, bit6=a ... bit0=g
dp_in  input  1  decimal point, active-low
an_in  input  NDIG  anode enables, active-low
dig_valid  output  1  one-cycle pulse: a digit was captured
dig_idx  output  $clog2(NDIG) (minimum 1)  index of the captured digit
dig_val  output  4  decoded nibble of the captured digit
dig_err  output  1  captured pattern was not a legal code
frame_valid  output  1  one-cycle pulse: a full frame is available
frame_val  output  4*NDIG  digit i occupies bits [4i+3:4i]
frame_dp  output  NDIG  decimal-point lit, per digit (active-high)
frame_blank  output  NDIG  digit was fully blank, per digit
frame_err  output  1  OR of the per-digit error flags across the frame

Behaviour:
- Reset (rst_n low at a clk edge): all outputs, the seen-mask, the stability counter and the sample registers go to 0. A reset asserted mid-frame discards all partially collected digits.
- Input stage: seg_in, dp_in and an_in are registered once into s_seg, s_dp and s_an. Inputs must already be synchronous to clk.
- One-hot check: a sample is valid when exactly one bit of an_in is 0. All-high (no digit) and multiple-low (ghosting) samples are invalid.
- Stability counter cnt, saturating at STABLE_CYC. At each edge:
  - Incoming sample valid and equal to {s_an, s_seg, s_dp}: cnt <= cnt+1.
  - Incoming sample valid but different: cnt <= 1.
  - Incoming sample invalid: cnt <= 0.
  - A single armed flag allows one capture per stable window; the flag re-arms whenever cnt restarts.
- Capture:
  - The edge after cnt first reaches STABLE_CYC writes the digit registers for the selected digit: nibble, err, blank and dp (dp_reg = ~s_dp). The same edge sets seen[idx].
  - dig_valid, dig_idx, dig_val and dig_err are driven for exactly that following cycle.
  - Latency with steady inputs and STABLE_CYC=4: dig_valid is high in the cycle after edge 5, counting from the first edge that samples the new value.
- Decode table (active-low):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9, 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F.
  - 1111111 = blank: nibble 0, blank=1, err=0.
  - Any other pattern, including the 1111110 dash: nibble 0, err=1.
- Recapture: a digit recaptured before the frame completes overwrites its previous value.
- Frame completion:
  - The capture that makes seen all-ones asserts frame_valid on the next edge. That edge also loads frame_val, frame_dp, frame_blank and frame_err from the digit registers, including the just-captured digit, and clears seen.
  - frame_* outputs hold until the next frame.
  - A capture in the same cycle as frame emission counts toward the next frame.
- frame_valid never asserts on two consecutive cycles.

Decomposition:
- Package seg7_pkg holds the 16 active-low pattern constants, SEG_BLANK=7'b1111111 and SEG_DASH=7'b1111110. These constants are shared with the encoder side.
- Sub-module seg7_lut_dec, purely combinational: seg[6:0] -> nibble[3:0], blank, err. It is unit-tested exhaustively over all 128 patterns.

Test Plan:
- Reset: rst_n low for 3 cycles with digit 8 driven on all anodes -> every output stays 0; no dig_valid for STABLE_CYC+1 cycles after release.
- Scan digits 3..0 showing 1, 2, 3, 4 (an_in 0111/1011/1101/1110), each held 8 cycles, with dp lit on digit 1:
  - four dig_valid pulses.
  - one frame_valid with frame_val=16'h1234, frame_dp=4'b0010, frame_err=0.
- Glitch: digit 0 shows 7 for only 3 cycles (STABLE_CYC=4), then an_in=1111 -> no dig_valid and seen unchanged.
- Invalid and blank: digit 2 shows 1111110 and digit 3 shows 1111111, digits 1 and 0 show A and F:
  - frame_val=16'h00AF, frame_err=1, frame_blank=4'b1000.
  - dig_err pulses with dig_idx=2.
- Ghosting: an_in=1100 held 20 cycles with a legal pattern -> no capture. Switching to 1110 then captures after exactly STABLE_CYC+1 edges.
- Reset mid-frame: capture digits 3, 2 and 1, pulse rst_n, then capture digit 0 only -> no frame_valid. A full frame emits only after all four digits are re-captured.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared active-low 7-segment code points (bit6=a ... bit0=g).
// The same constants are used by the encoder and by the scan decoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       err;
    } seg_dec_t;

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        logic [6:0] c;
        case (n)
            4'h0: c = SEG_0;
            4'h1: c = SEG_1;
            4'h2: c = SEG_2;
            4'h3: c = SEG_3;
            4'h4: c = SEG_4;
            4'h5: c = SEG_5;
            4'h6: c = SEG_6;
            4'h7: c = SEG_7;
            4'h8: c = SEG_8;
            4'h9: c = SEG_9;
            4'hA: c = SEG_A;
            4'hB: c = SEG_B;
            4'hC: c = SEG_C;
            4'hD: c = SEG_D;
            4'hE: c = SEG_E;
            default: c = SEG_F;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_lut_dec.sv
// Combinational active-low segment pattern to hex nibble decoder.
// Blank decodes as nibble 0 without error; unknown patterns flag err.
module seg7_lut_dec
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       err
);

    always_comb begin
        nibble = 4'h0;
        blank  = (seg == SEG_BLANK);
        err    = !blank;
        for (int i = 0; i < 16; i++) begin
            if (seg == seg_code(4'(i))) begin
                nibble = 4'(i);
                err    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed active-low display bus, captures each digit once
// it has been stable, and emits a full frame once every digit refreshed.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 4,
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1,
    localparam int CW = $clog2(STABLE_CYC + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
    input  logic              dp_in,
    input  logic [NDIG-1:0]   an_in,
    output logic              dig_valid,
    output logic [IW-1:0]     dig_idx,
    output logic [3:0]        dig_val,
    output logic              dig_err,
    output logic              frame_valid,
    output logic [4*NDIG-1:0] frame_val,
    output logic [NDIG-1:0]   frame_dp,
    output logic [NDIG-1:0]   frame_blank,
    output logic              frame_err
);

    logic [NDIG-1:0]       s_an_q;
    logic [6:0]            s_seg_q;
    logic                  s_dp_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  armed_q, armed_d;
    logic [NDIG-1:0]       seen_q, seen_d;
    logic [NDIG-1:0][3:0]  nib_q, nib_d;
    logic [NDIG-1:0]       err_q, err_d;
    logic [NDIG-1:0]       blank_q, blank_d;
    logic [NDIG-1:0]       dp_q, dp_d;

    logic                  dig_valid_q, dig_valid_d;
    logic [IW-1:0]         dig_idx_q, dig_idx_d;
    logic [3:0]            dig_val_q, dig_val_d;
    logic                  dig_err_q, dig_err_d;
    logic                  frame_valid_q, frame_valid_d;
    logic [4*NDIG-1:0]     frame_val_q, frame_val_d;
    logic [NDIG-1:0]       frame_dp_q, frame_dp_d;
    logic [NDIG-1:0]       frame_blank_q, frame_blank_d;
    logic                  frame_err_q, frame_err_d;

    logic                  in_valid;
    logic                  same;
    logic                  capture;
    logic                  emit;
    logic [IW-1:0]         cap_idx;
    seg_dec_t              dec;

    seg7_lut_dec u_dec (
        .seg    (s_seg_q),
        .nibble (dec.nib),
        .blank  (dec.blank),
        .err    (dec.err)
    );

    always_comb begin
        in_valid = $onehot(~an_in);
        same     = ({an_in, seg_in, dp_in} == {s_an_q, s_seg_q, s_dp_q});
        capture  = armed_q && (cnt_q == CW'(STABLE_CYC));
        // Gate on frame_valid_q so frames can never be back to back.
        emit     = (&seen_q) && !frame_valid_q;

        cap_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (!s_an_q[i]) cap_idx = IW'(i);
        end

        if (!in_valid) begin
            cnt_d   = '0;
            armed_d = 1'b1;
        end else if (!same) begin
            cnt_d   = CW'(1);
            armed_d = 1'b1;
        end else begin
            cnt_d   = (cnt_q == CW'(STABLE_CYC)) ? cnt_q : cnt_q + 1'b1;
            armed_d = armed_q && !capture;
        end

        seen_d  = emit ? '0 : seen_q;
        nib_d   = nib_q;
        err_d   = err_q;
        blank_d = blank_q;
        dp_d    = dp_q;
        if (capture) begin
            seen_d[cap_idx]  = 1'b1;
            nib_d[cap_idx]   = dec.nib;
            err_d[cap_idx]   = dec.err;
            blank_d[cap_idx] = dec.blank;
            dp_d[cap_idx]    = ~s_dp_q;
        end

        dig_valid_d = capture;
        dig_idx_d   = capture ? cap_idx : '0;
        dig_val_d   = capture ? dec.nib : 4'h0;
        dig_err_d   = capture && dec.err;

        frame_valid_d = emit;
        frame_val_d   = emit ? nib_q   : frame_val_q;
        frame_dp_d    = emit ? dp_q    : frame_dp_q;
        frame_blank_d = emit ? blank_q : frame_blank_q;
        frame_err_d   = emit ? |err_q  : frame_err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_an_q        <= '0;
            s_seg_q       <= '0;
            s_dp_q        <= 1'b0;
            cnt_q         <= '0;
            armed_q       <= 1'b1;
            seen_q        <= '0;
            nib_q         <= '0;
            err_q         <= '0;
            blank_q       <= '0;
            dp_q          <= '0;
            dig_valid_q   <= 1'b0;
            dig_idx_q     <= '0;
            dig_val_q     <= '0;
            dig_err_q     <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_val_q   <= '0;
            frame_dp_q    <= '0;
            frame_blank_q <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            s_an_q        <= an_in;
            s_seg_q       <= seg_in;
            s_dp_q        <= dp_in;
            cnt_q         <= cnt_d;
            armed_q       <= armed_d;
            seen_q        <= seen_d;
            nib_q         <= nib_d;
            err_q         <= err_d;
            blank_q       <= blank_d;
            dp_q          <= dp_d;
            dig_valid_q   <= dig_valid_d;
            dig_idx_q     <= dig_idx_d;
            dig_val_q     <= dig_val_d;
            dig_err_q     <= dig_err_d;
            frame_valid_q <= frame_valid_d;
            frame_val_q   <= frame_val_d;
            frame_dp_q    <= frame_dp_d;
            frame_blank_q <= frame_blank_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign dig_valid   = dig_valid_q;
    assign dig_idx     = dig_idx_q;
    assign dig_val     = dig_val_q;
    assign dig_err     = dig_err_q;
    assign frame_valid = frame_valid_q;
    assign frame_val   = frame_val_q;
    assign frame_dp    = frame_dp_q;
    assign frame_blank = frame_blank_q;
    assign frame_err   = frame_err_q;

endmodule
